// File: rtl/tx_arbiter_rr.sv
// tx_arbiter_rr: round-robin frame arbiter. It merges SOURCES framed word
// streams into one registered output stream. Each granted frame can be
// prefixed with a header word (HEADER_BASE + source index). A frame that
// stalls for TIMEOUT DATA cycles without a capture is aborted.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   src_data/rdy/eof    per-source word, valid and end-of-frame
//   src_ack             one-cycle pulse: word of the granted source consumed
//   tx_data/tx_rdy      registered output word and its valid flag
//   tx_ack              sink accepts tx_data
//   grant_o             current or last granted source index
//   busy                arbiter is inside a frame (HEADER or DATA)
//   abort_o             one-cycle pulse when a frame times out
//   state_dbg           FSM state (0 IDLE, 1 HEADER, 2 DATA)
//
// Handshake: a word moves from source i when src_rdy[i] && src_ack[i] in the
// same cycle. src_ack is combinational, so a source may present its next word
// in the following cycle. A word leaves on tx_data when tx_rdy && tx_ack.
// tx_ack while tx_rdy is low has no effect.
module tx_arbiter_rr #(
  parameter int SOURCES = 4,
  parameter int DATA_WIDTH = 8,
  parameter int HEADER_EN = 1,
  parameter logic [DATA_WIDTH-1:0] HEADER_BASE = 8'hA0,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SOURCES*DATA_WIDTH-1:0] src_data,
  input  logic [SOURCES-1:0]            src_rdy,
  input  logic [SOURCES-1:0]            src_eof,
  output logic [SOURCES-1:0]            src_ack,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_rdy,
  input  logic                          tx_ack,
  output logic [$clog2(SOURCES)-1:0]    grant_o,
  output logic                          busy,
  output logic                          abort_o,
  output logic [1:0]                    state_dbg
);

  localparam int GW = $clog2(SOURCES);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HEADER = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;

  logic [1:0]            state;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         pick;
  logic                  found;
  logic [GW:0]           cand;
  logic [TW-1:0]         tmo_cnt;
  logic                  loadable;
  logic                  capture;
  logic [DATA_WIDTH-1:0] cur_word;
  logic                  cur_eof;
  logic [DATA_WIDTH-1:0] hdr_word;

  // The output register may take a new word when it is empty or when its
  // current word leaves in this same cycle.
  assign loadable = !tx_rdy || tx_ack;
  assign cur_word = src_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign cur_eof  = src_eof[grant];
  assign capture  = (state == ST_DATA) && src_rdy[grant] && loadable;
  assign hdr_word = HEADER_BASE + DATA_WIDTH'(grant);

  assign busy      = (state == ST_HEADER) || (state == ST_DATA);
  assign grant_o   = grant;
  assign state_dbg = state;

  always_comb begin
    src_ack = '0;
    if (capture) src_ack[grant] = 1'b1;
  end

  // Round-robin search: scan last_grant+1, last_grant+2, ... and wrap, so that
  // the source granted last has the lowest priority. cand is one bit wider
  // than an index so that the sum before the wrap cannot overflow.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= SOURCES; k++) begin
      cand = {1'b0, last_grant} + (GW+1)'(k);
      if (cand >= (GW+1)'(SOURCES)) cand = cand - (GW+1)'(SOURCES);
      if (!found && src_rdy[cand[GW-1:0]]) begin
        found = 1'b1;
        pick  = cand[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GW'(SOURCES - 1);
      tx_data    <= '0;
      tx_rdy     <= 1'b0;
      abort_o    <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      abort_o <= 1'b0;
      // A transfer empties the register. A load later in this block
      // overrides this and keeps tx_rdy high.
      if (tx_rdy && tx_ack) tx_rdy <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant   <= pick;
            tmo_cnt <= '0;
            state   <= (HEADER_EN != 0) ? ST_HEADER : ST_DATA;
          end
        end
        ST_HEADER: begin
          if (loadable) begin
            tx_data <= hdr_word;
            tx_rdy  <= 1'b1;
            tmo_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (capture) begin
            tx_data <= cur_word;
            tx_rdy  <= 1'b1;
            tmo_cnt <= '0;
            if (cur_eof) begin
              last_grant <= grant;
              state      <= ST_IDLE;
            end
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th DATA cycle in a row without a capture.
            abort_o    <= 1'b1;
            last_grant <= grant;
            tmo_cnt    <= '0;
            state      <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
